fifo_param: RTL and testbench

Parametrised synchronous FIFO for the DE1-SoC lab designs. It generalises the board's fixed 16×8 button-driven FIFO in data width, depth and read mode. It adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and an optional first-word-fall-through (FWFT) mode. It sits between the debounced `buttonPress` strobes and the `seg7_hex`/LEDR outputs, and is also usable as a generic buffer between on-chip blocks.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/fifo_ram.sv | 32 +++
 rtl/fifo_param.sv | 108 ++++++++++
 tb/tb_fifo_param.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared helpers and parameter-legality checks for fifo_param.
// Revision    : 1.0
// ============================================================================
package fifo_pkg;

  function automatic int addr_w(int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic bit is_pow2(int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_ok(int data_w, int depth, int af, int ae, int fwft);
    return (data_w >= 1) && is_pow2(depth) &&
           (af >= 1) && (af <= depth) &&
           (ae >= 0) && (ae <= depth - 1) &&
           ((fwft == 0) || (fwft == 1));
  endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ram
// Description : DEPTH x DATA_W register array, one sync write, one async read.
// Revision    : 1.0
// ============================================================================
module fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // Storage is deliberately not reset; the read path masks stale contents.
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule : fifo_ram
`default_nettype wire

// File: rtl/fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : fifo_param
// Description : Parametrised synchronous FIFO with occupancy, threshold flags,
//               sticky error flags and optional first-word-fall-through.
// Revision    : 1.0
// ============================================================================
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write,
  input  logic                     read,
  input  logic                     clear_err,
  input  logic [DATA_W-1:0]        inputBus,
  output logic [DATA_W-1:0]        outputBus,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam logic [ADDR_W:0] c_af = (ADDR_W + 1)'(AF_THRESH);
  localparam logic [ADDR_W:0] c_ae = (ADDR_W + 1)'(AE_THRESH);

  if (!params_ok(DATA_W, DEPTH, AF_THRESH, AE_THRESH, FWFT)) begin : g_bad_params
    $error("fifo_param: illegal parameter set");
  end

  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic              r_overflow;
  logic              r_underflow;
  logic              w_rd_ok;
  logic              w_wr_ok;
  logic [DATA_W-1:0] w_rd_data;

  assign empty        = (r_wr_ptr == r_rd_ptr);
  assign full         = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                        (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);
  assign count        = r_wr_ptr - r_rd_ptr;
  assign almost_full  = (count >= c_af);
  assign almost_empty = (count <= c_ae);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // A write into a full FIFO is only legal when paired with an accepted read.
  assign w_rd_ok = read && !empty;
  assign w_wr_ok = write && (!full || w_rd_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      // Setting beats clearing when both happen in the same cycle.
      r_overflow  <= (write && !w_wr_ok) || (r_overflow  && !clear_err);
      r_underflow <= (read  && !w_rd_ok) || (r_underflow && !clear_err);
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we      (w_wr_ok),
    .wr_addr (r_wr_ptr[ADDR_W-1:0]),
    .wr_data (inputBus),
    .rd_addr (r_rd_ptr[ADDR_W-1:0]),
    .rd_data (w_rd_data)
  );

  if (FWFT != 0) begin : g_fwft
    assign outputBus = empty ? '0 : w_rd_data;
  end else begin : g_std
    logic [DATA_W-1:0] r_out;

    // Async read of the old entry makes same-address full read/write read-first.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_out <= '0;
      end else if (w_rd_ok) begin
        r_out <= w_rd_data;
      end
    end

    assign outputBus = r_out;
  end

endmodule : fifo_param
`default_nettype wire

// File: tb/tb_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_param
// Description : Self-checking bench; standard and FWFT instances share stimulus
//               and are compared against a queue-based reference model.
// Revision    : 1.0
// ============================================================================
module tb_fifo_param;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0, write = 1'b0, read = 1'b0, clear_err = 1'b0;
  logic [DW-1:0] inputBus = '0;

  logic [DW-1:0] ob0, ob1;
  logic          e0, f0, ae0, af0, ov0, un0;
  logic          e1, f1, ae1, af1, ov1, un1;
  logic [4:0]    cnt0, cnt1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) dut_std (
    .clk(clk), .reset(reset), .write(write), .read(read), .clear_err(clear_err),
    .inputBus(inputBus), .outputBus(ob0), .empty(e0), .full(f0),
    .almost_empty(ae0), .almost_full(af0), .count(cnt0),
    .overflow(ov0), .underflow(un0)
  );

  fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) dut_fwft (
    .clk(clk), .reset(reset), .write(write), .read(read), .clear_err(clear_err),
    .inputBus(inputBus), .outputBus(ob1), .empty(e1), .full(f1),
    .almost_empty(ae1), .almost_full(af1), .count(cnt1),
    .overflow(ov1), .underflow(un1)
  );

  // Reference model: a plain queue plus the two sticky flags and the std read register.
  logic [DW-1:0] q[$];
  bit            m_ovf, m_unf;
  logic [DW-1:0] m_out0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare(input string p, input logic [4:0] cnt, input logic e, input logic f,
                         input logic ae, input logic af, input logic ov, input logic un,
                         input logic [DW-1:0] ob, input logic [DW-1:0] exp_ob);
    int n;
    n = q.size();
    check({p, "count"},        32'(cnt), 32'(n));
    check({p, "empty"},        32'(e),   32'(n == 0));
    check({p, "full"},         32'(f),   32'(n == DEPTH));
    check({p, "almost_empty"}, 32'(ae),  32'(n <= AE));
    check({p, "almost_full"},  32'(af),  32'(n >= AF));
    check({p, "overflow"},     32'(ov),  32'(m_ovf));
    check({p, "underflow"},    32'(un),  32'(m_unf));
    check({p, "outputBus"},    32'(ob),  32'(exp_ob));
  endtask

  task automatic step(input bit r, input bit w, input bit rd, input bit c, input logic [DW-1:0] d);
    bit rd_acc, wr_acc;
    @(negedge clk);
    reset = r; write = w; read = rd; clear_err = c; inputBus = d;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_out0 = '0;
    end else begin
      rd_acc = rd && (q.size() > 0);
      wr_acc = w && ((q.size() < DEPTH) || rd);
      if (rd_acc) begin
        m_out0 = q[0];
        void'(q.pop_front());
      end
      if (wr_acc) q.push_back(d);
      m_ovf = (w && !wr_acc) || (m_ovf && !c);
      m_unf = (rd && !rd_acc) || (m_unf && !c);
    end
    #1;
    compare("std.",  cnt0, e0, f0, ae0, af0, ov0, un0, ob0, m_out0);
    compare("fwft.", cnt1, e1, f1, ae1, af1, ov1, un1, ob1, (q.size() > 0) ? q[0] : '0);
  endtask

  task automatic fill_1_to_16();
    for (int i = 1; i <= DEPTH; i++) step(0, 1, 0, 0, DW'(i));
  endtask

  initial begin
    // Reset, then a read on empty raises underflow; clear_err drops it.
    step(1, 0, 0, 0, '0);
    step(0, 0, 1, 0, '0);
    check("plan.underflow_set", 32'(un0), 32'd1);
    check("plan.ob_after_reset", 32'(ob0), 32'h00);
    step(0, 0, 0, 1, '0);
    check("plan.underflow_cleared", 32'(un0), 32'd0);

    // Fill, then overflow with 0xAA.
    fill_1_to_16();
    step(0, 1, 0, 0, 8'hAA);
    check("plan.overflow_set", 32'(ov0), 32'd1);
    check("plan.count_full", 32'(cnt0), 32'd16);

    // Drain in order.
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0, '0);
    check("plan.last_read", 32'(ob0), 32'h10);

    // Full FIFO: simultaneous read/write, then drain to see 0x55 come out last.
    step(0, 0, 0, 1, '0);
    fill_1_to_16();
    step(0, 1, 1, 0, 8'h55);
    check("plan.pop_while_full", 32'(ob0), 32'h01);
    check("plan.count_stays_16", 32'(cnt0), 32'd16);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0, '0);
    check("plan.wrap_last_word", 32'(ob0), 32'h55);

    // Empty FIFO: read and write together; only the write is taken.
    step(0, 1, 1, 0, 8'h33);
    check("plan.empty_rw_underflow", 32'(un0), 32'd1);
    step(0, 0, 1, 0, '0);
    check("plan.empty_rw_data", 32'(ob0), 32'h33);

    // FWFT shows the word without a read; reset mid-operation discards contents.
    step(0, 1, 0, 1, 8'h7E);
    check("plan.fwft_show", 32'(ob1), 32'h7E);
    step(0, 0, 1, 0, '0);
    check("plan.fwft_drained", 32'(ob1), 32'h00);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, DW'(8'hC0 + i));
    step(1, 1, 1, 0, 8'hEE);
    check("plan.reset_count", 32'(cnt1), 32'd0);

    // Randomised traffic with shifting read/write bias.
    for (int seg = 0; seg < 12; seg++) begin
      int pw, pr;
      pw = (seg % 3 == 0) ? 80 : (seg % 3 == 1) ? 20 : 50;
      pr = (seg % 3 == 0) ? 20 : (seg % 3 == 1) ? 80 : 50;
      for (int i = 0; i < 200; i++) begin
        step(($urandom_range(0, 299) == 0),
             ($urandom_range(0, 99) < pw),
             ($urandom_range(0, 99) < pr),
             ($urandom_range(0, 19) == 0),
             DW'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fifo_param
`default_nettype wire
